// File: rtl/clock_period_meter.sv
// Measures the period and high time of an asynchronous clock-like input in clk_i cycles,
// flagging when consecutive periods match (locked) or when edges stop arriving (lost).
module clock_period_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             sig_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             lost_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE,
        LOST
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           r_state;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_locked;
    logic             r_lost;
    logic             r_have_prev;

    logic             w_rise;
    logic             w_timeout;
    logic [CNT_W-1:0] w_hinc;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_timeout = (r_cnt == TIMEOUT_C);
    assign w_hinc    = {{(CNT_W-1){1'b0}}, r_s2};

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high      <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_lost      <= 1'b0;
            r_have_prev <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!en_i) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_hcnt      <= '0;
                r_locked    <= 1'b0;
                r_lost      <= 1'b0;
                r_have_prev <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= WAIT_FIRST;
                        r_cnt   <= '0;
                        r_hcnt  <= '0;
                    end
                    WAIT_FIRST: begin
                        if (w_rise) begin
                            r_state     <= MEASURE;
                            r_cnt       <= ONE_C;
                            r_hcnt      <= ONE_C;
                            r_have_prev <= 1'b0;
                        end else if (w_timeout) begin
                            r_state  <= LOST;
                            r_lost   <= 1'b1;
                            r_locked <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + ONE_C;
                        end
                    end
                    MEASURE: begin
                        // A rise coinciding with the timeout still counts as a measurement.
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high      <= r_hcnt;
                            r_valid     <= 1'b1;
                            r_locked    <= r_have_prev && (r_cnt == r_period);
                            r_have_prev <= 1'b1;
                            r_cnt       <= ONE_C;
                            r_hcnt      <= ONE_C;
                        end else if (w_timeout) begin
                            r_state  <= LOST;
                            r_lost   <= 1'b1;
                            r_locked <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt + ONE_C;
                            r_hcnt <= r_hcnt + w_hinc;
                        end
                    end
                    LOST: begin
                        if (w_rise) begin
                            r_state     <= MEASURE;
                            r_lost      <= 1'b0;
                            r_cnt       <= ONE_C;
                            r_hcnt      <= ONE_C;
                            r_have_prev <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign period_o = r_period;
    assign high_o   = r_high;
    assign valid_o  = r_valid;
    assign locked_o = r_locked;
    assign lost_o   = r_lost;

endmodule
